// File: rtl/wb_pkg.sv
// Shared Wishbone types and widths for the single-transfer initiator.
package wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
  } wb_cmd_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack timeout counter: cleared on launch, counts bus cycles, flags the last allowed one.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wishbone_initiator.sv
// Wishbone classic single-transfer master with valid/ready command and response ports.
module wishbone_initiator
  import wb_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [WB_DAT_W-1:0]   ERR_DATA       = WB_ERR_DATA
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);
  wb_state_e state_q, state_d;
  wb_cmd_t   bus_q;
  logic      launch, ack_done, to_done, rsp_pop, expired;

  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (launch),
    .en       (state_q == BUS),
    .expired  (expired)
  );

  assign cmd_ready = (state_q == IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ack is only looked at in BUS, so a lingering registered ack is harmless
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    ack_done = 1'b0;
    to_done  = 1'b0;
    rsp_pop  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        launch  = 1'b1;
        state_d = BUS;
      end
      BUS: if (wbm_ack_i) begin
        ack_done = 1'b1;
        state_d  = RESP;
      end else if (expired) begin
        to_done = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_pop = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus_q     <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (launch) begin
        bus_q     <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
      end
      // we/adr/sel/dat intentionally keep their last values after the cycle ends
      if (ack_done || to_done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= to_done;
        rsp_dat   <= bus_q.we ? '0 : (ack_done ? wbm_dat_i : ERR_DATA);
      end
      if (rsp_pop) rsp_valid <= 1'b0;
    end
  end

  assign wbm_we_o  = bus_q.we;
  assign wbm_adr_o = bus_q.adr;
  assign wbm_dat_o = bus_q.dat;
  assign wbm_sel_o = bus_q.sel;
endmodule

// File: tb/tb_wishbone_initiator.sv
// Scoreboard bench for wishbone_initiator with a mode-selectable behavioural slave.
module tb_wishbone_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  // slave modes: 0 zero-wait, 1 registered ack, 2 never ack, 3 ack on 8th strobe cycle
  int          slave_mode = 0;
  logic [31:0] slave_rdata = '0;
  logic        ack_q = 1'b0;
  int          bus_cnt = 0;

  always #5 clk = ~clk;

  wishbone_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always_ff @(posedge clk) begin
    ack_q   <= wbm_cyc_o & wbm_stb_o & (slave_mode == 1);
    bus_cnt <= wbm_stb_o ? bus_cnt + 1 : 0;
  end

  always_comb begin
    wbm_ack_i = 1'b0;
    case (slave_mode)
      0: wbm_ack_i = wbm_cyc_o & wbm_stb_o;
      1: wbm_ack_i = ack_q;
      3: wbm_ack_i = wbm_cyc_o & wbm_stb_o & (bus_cnt == 7);
      default: wbm_ack_i = 1'b0;
    endcase
  end

  assign wbm_dat_i = (slave_mode == 1 && wbm_adr_o != 32'h3000_0000) ? 32'h0 : slave_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      else begin
        e = sb.pop_front();
        check("rsp_dat", rsp_dat, e.dat);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Returns at accept edge + 1.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] edat, input logic eerr);
    rsp_t e;
    int   n;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", {31'b0, cmd_ready}, 32'h1);
    e.dat = edat; e.err = eerr;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drain", sb.size(), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic count_stb(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!wbm_stb_o) break;
      n++;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc",       {31'b0, wbm_cyc_o}, 32'h0);
    check("rst_stb",       {31'b0, wbm_stb_o}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_adr",       wbm_adr_o,          32'h0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // write, zero-wait slave
    slave_mode = 0;
    send(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    check("wr_stb", {31'b0, wbm_stb_o}, 32'h1);
    check("wr_cyc", {31'b0, wbm_cyc_o}, 32'h1);
    check("wr_we",  {31'b0, wbm_we_o},  32'h1);
    check("wr_adr", wbm_adr_o,          32'h3000_0004);
    check("wr_dat", wbm_dat_o,          32'h1234_5678);
    check("wr_sel", {28'b0, wbm_sel_o}, 32'hF);
    @(posedge clk); #1;
    check("wr_cyc_drop",  {31'b0, wbm_cyc_o}, 32'h0);
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check("wr_adr_hold",  wbm_adr_o,          32'h3000_0004);
    drain();

    // read, registered-ack slave with lingering ack
    slave_mode = 1; slave_rdata = 32'hCAFE_F00D;
    send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("linger_no_cyc", {31'b0, wbm_cyc_o}, 32'h0);

    // timeout read, then a normal command
    slave_mode = 2;
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    count_stb(n);
    check("to_stb_cycles", n, 32'd8);
    drain();
    slave_mode = 0;
    send(1'b1, 32'h3000_0008, 32'hA5A5_A5A5, 4'h3, 32'h0, 1'b0);
    drain();

    // ack on the expiry cycle beats the timeout
    slave_mode = 3; slave_rdata = 32'h5A5A_1234;
    send(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'h5A5A_1234, 1'b0);
    count_stb(n);
    check("race_stb_cycles", n, 32'd8);
    drain();

    // response backpressure
    slave_mode = 0; slave_rdata = 32'h1111_2222; rsp_ready = 1'b0;
    send(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h1111_2222, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_valid = 1'b1;
      end
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check("bp_rsp_dat",   rsp_dat,            32'h1111_2222);
      check("bp_rsp_err",   {31'b0, rsp_err},   32'h0);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("bp_no_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rsp_clear", {31'b0, rsp_valid}, 32'h0);
    check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    drain();

    // asynchronous reset mid-transfer
    slave_mode = 2;
    send(1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    check("arst_stb", {31'b0, wbm_stb_o}, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("post_rst_cyc",       {31'b0, wbm_cyc_o}, 32'h0);
    slave_mode = 0; slave_rdata = 32'h0BAD_F00D;
    send(1'b0, 32'h3000_0044, 32'h0, 4'h1, 32'h0BAD_F00D, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
